// File: rtl/pm_multi_counter.sv
// pm_multi_counter
//   Multi-channel low-pulse occupancy counter for particulate-matter sensors.
//   Each channel counts the clock cycles during which its active-low sensor
//   output is asserted. A latch event snapshots every channel at once. The
//   snapshots, the status byte and the control byte are readable as bytes on
//   the membus.
//
//   Build option: define PM_COUNTER_SYNC_EN to pass pm_input_i and pm_latch_i
//   through 2-flop synchronisers. Without it, both inputs are used directly.
//
// Parameters
//   MEMBUS_ADDRESS  base byte address of the register window
//   NUM_CH          number of channels, 1..4
//   CNT_W           counter width, 8..32, a multiple of 8
//
// Ports
//   clk_i, rst_n_i        clock (posedge), asynchronous active-low reset
//   membus_read_req_i     read strobe
//   membus_write_req_i    write strobe
//   membus_addr_i         byte address
//   membus_data_i         write data
//   membus_data_o         registered read data, one cycle after the read;
//                         8'hZZ when this block is not driving
//   pm_input_i            per-channel sensor output, active low
//   pm_latch_i            latch request, rising-edge active
//   dbg_counting_o        registered ~pm_input (after optional sync)
//   sample_ready_o        high while a snapshot has not been read via STATUS
//
// Register map (offsets from MEMBUS_ADDRESS)
//   +0            STATUS  RO  bit7 sample_ready, bits[NUM_CH-1:0] latched sat
//   +1            CONTROL RW  bit0 ENABLE (reset 1), bit1 SOFT_LATCH (pulse)
//   +2+c*CB+b     RO          byte b of channel c snapshot, little-endian

// One counter channel: live counter with saturation, plus its snapshot.
module pm_mc_channel #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             count,    // count this cycle (enable & input low)
    input  logic             latch,    // snapshot event
    output logic [CNT_W-1:0] latched,
    output logic             lsat
);
    logic [CNT_W-1:0] cnt;
    logic             sat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            sat     <= 1'b0;
            latched <= '0;
            lsat    <= 1'b0;
        end else if (latch) begin
            // Snapshot excludes this cycle's sample; that sample starts the
            // next interval instead.
            latched <= cnt;
            lsat    <= sat;
            cnt     <= {{(CNT_W-1){1'b0}}, count};
            sat     <= 1'b0;
        end else if (count) begin
            if (&cnt) sat <= 1'b1;
            else      cnt <= cnt + 1'b1;
        end
    end
endmodule

module pm_multi_counter #(
    parameter logic [7:0] MEMBUS_ADDRESS = 8'h10,
    parameter int         NUM_CH         = 2,
    parameter int         CNT_W          = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              membus_read_req_i,
    input  logic              membus_write_req_i,
    input  logic [6:0]        membus_addr_i,
    input  logic [7:0]        membus_data_i,
    output logic [7:0]        membus_data_o,
    input  logic [NUM_CH-1:0] pm_input_i,
    input  logic              pm_latch_i,
    output logic [NUM_CH-1:0] dbg_counting_o,
    output logic              sample_ready_o
);
    localparam int         NB       = 2 + NUM_CH * CNT_W / 8;
    localparam logic [7:0] TOP_ADDR = MEMBUS_ADDRESS + 8'(NB);

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0] pm_s;
    logic              latch_s;

`ifdef PM_COUNTER_SYNC_EN
    logic [NUM_CH-1:0] pm_m;
    logic              latch_m;

    // pm flops reset to the idle (not counting) level.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pm_m    <= '1;
            pm_s    <= '1;
            latch_m <= 1'b0;
            latch_s <= 1'b0;
        end else begin
            pm_m    <= pm_input_i;
            pm_s    <= pm_m;
            latch_m <= pm_latch_i;
            latch_s <= latch_m;
        end
    end
`else
    assign pm_s    = pm_input_i;
    assign latch_s = pm_latch_i;
`endif

    // ------------------------------------------------------------------
    // Latch edge detection. 'armed' stays low until the latch input has
    // been seen low once, so a latch held high across reset release does
    // not produce an event.
    // ------------------------------------------------------------------
    logic latch_prev;
    logic armed;
    logic latch_edge;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            latch_prev <= 1'b0;
            armed      <= 1'b0;
        end else begin
            latch_prev <= latch_s;
            if (!latch_s) armed <= 1'b1;
        end
    end

    assign latch_edge = armed & ~latch_prev & latch_s;

    // ------------------------------------------------------------------
    // Membus decode
    // ------------------------------------------------------------------
    logic [7:0] addr8;
    logic [7:0] off;
    logic       hit;
    logic       wr_ctrl;
    logic       rd_status;
    logic       evt;
    logic       enable;
    logic       sample_ready;
    logic       unused_wdata;

    assign addr8     = {1'b0, membus_addr_i};
    assign off       = addr8 - MEMBUS_ADDRESS;
    assign hit       = (addr8 >= MEMBUS_ADDRESS) && (addr8 < TOP_ADDR);
    assign wr_ctrl   = membus_write_req_i && hit && (off == 8'd1);
    assign rd_status = membus_read_req_i && hit && (off == 8'd0);
    // Hardware and software latch in the same cycle merge into one event.
    assign evt       = latch_edge | (wr_ctrl & membus_data_i[1]);
    assign unused_wdata = ^membus_data_i[7:2];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            enable       <= 1'b1;
            sample_ready <= 1'b0;
        end else begin
            if (wr_ctrl) enable <= membus_data_i[0];
            // A new snapshot wins over a STATUS read that clears the flag.
            if (evt)            sample_ready <= 1'b1;
            else if (rd_status) sample_ready <= 1'b0;
        end
    end

    assign sample_ready_o = sample_ready;

    // ------------------------------------------------------------------
    // Channels
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0][CNT_W-1:0] latched;
    logic [NUM_CH*CNT_W-1:0]      lat_flat;
    logic [NUM_CH-1:0]            lsat;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        pm_mc_channel #(.CNT_W(CNT_W)) u_ch (
            .clk     (clk_i),
            .rst_n   (rst_n_i),
            .count   (enable & ~pm_s[c]),
            .latch   (evt),
            .latched (latched[c]),
            .lsat    (lsat[c])
        );
    end

    // Channel 0 sits in the low bits, so byte i of the flat vector is the
    // register at offset 2+i.
    assign lat_flat = latched;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) dbg_counting_o <= '0;
        else          dbg_counting_o <= ~pm_s;
    end

    // ------------------------------------------------------------------
    // Read path: byte mux from current (pre-event) state, then register.
    // ------------------------------------------------------------------
    logic [7:0] rd_byte;
    logic [7:0] rd_q;
    logic       drv;

    always_comb begin
        rd_byte = '0;
        if (off == 8'd0) begin
            rd_byte[7]        = sample_ready;
            rd_byte[NUM_CH-1:0] = lsat;
        end else if (off == 8'd1) begin
            rd_byte[0] = enable;
        end else begin
            for (int i = 0; i < NB - 2; i++)
                if (off == 8'(i + 2)) rd_byte = lat_flat[i*8 +: 8];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_q <= '0;
            drv  <= 1'b0;
        end else begin
            drv <= membus_read_req_i && hit;
            if (membus_read_req_i && hit) rd_q <= rd_byte;
        end
    end

    assign membus_data_o = drv ? rd_q : 8'hzz;
endmodule

// File: tb/tb_pm_multi_counter.sv
// Bench for pm_multi_counter: a 32-bit and an 8-bit instance share all
// inputs. Each read bus has pull-ups, so an undriven (8'hZZ) bus reads 8'hFF.
module tb_pm_multi_counter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rd = 1'b0;
    logic       wr = 1'b0;
    logic [6:0] addr = '0;
    logic [7:0] wdata = '0;
    logic [1:0] pm = 2'b11;
    logic       latch = 1'b0;
    wire  [7:0] bus32;
    wire  [7:0] bus8;
    logic [1:0] dbg32, dbg8;
    logic       sr32, sr8;
    int         n_tests = 0;
    int         n_fail = 0;
    logic [7:0] d32, d8;

    always #5 clk = ~clk;

    for (genvar i = 0; i < 8; i++) begin : g_pu
        pullup (bus32[i]);
        pullup (bus8[i]);
    end

    pm_multi_counter #(.MEMBUS_ADDRESS(8'h10), .NUM_CH(2), .CNT_W(32)) dut32 (
        .clk_i(clk), .rst_n_i(rst_n), .membus_read_req_i(rd),
        .membus_write_req_i(wr), .membus_addr_i(addr), .membus_data_i(wdata),
        .membus_data_o(bus32), .pm_input_i(pm), .pm_latch_i(latch),
        .dbg_counting_o(dbg32), .sample_ready_o(sr32));

    pm_multi_counter #(.MEMBUS_ADDRESS(8'h10), .NUM_CH(2), .CNT_W(8)) dut8 (
        .clk_i(clk), .rst_n_i(rst_n), .membus_read_req_i(rd),
        .membus_write_req_i(wr), .membus_addr_i(addr), .membus_data_i(wdata),
        .membus_data_o(bus8), .pm_input_i(pm), .pm_latch_i(latch),
        .dbg_counting_o(dbg8), .sample_ready_o(sr8));

    typedef struct {
        string      name;
        logic [6:0] addr;
        logic [7:0] exp32;
        logic [7:0] exp8;
    } vec_t;

    vec_t vecs[13];

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic rd_reg(input logic [6:0] a, output logic [7:0] r32, output logic [7:0] r8);
        rd = 1'b1; addr = a;
        tick();
        rd = 1'b0;
        r32 = bus32; r8 = bus8;
    endtask

    task automatic wr_reg(input logic [6:0] a, input logic [7:0] d);
        wr = 1'b1; addr = a; wdata = d;
        tick();
        wr = 1'b0;
    endtask

    task automatic pulse_latch();
        latch = 1'b1; tick();
        latch = 1'b0; tick();
    endtask

    initial begin
        // Register contents after the first 100-cycle snapshot (ch0 = 100).
        vecs[0]  = '{"status",      7'h10, 8'h80, 8'h80};
        vecs[1]  = '{"control",     7'h11, 8'h01, 8'h01};
        vecs[2]  = '{"ch0_b0",      7'h12, 8'h64, 8'h64};
        vecs[3]  = '{"byte3",       7'h13, 8'h00, 8'h00};
        vecs[4]  = '{"byte4",       7'h14, 8'h00, 8'hFF};
        vecs[5]  = '{"byte5",       7'h15, 8'h00, 8'hFF};
        vecs[6]  = '{"ch1_b0",      7'h16, 8'h00, 8'hFF};
        vecs[7]  = '{"ch1_b1",      7'h17, 8'h00, 8'hFF};
        vecs[8]  = '{"ch1_b2",      7'h18, 8'h00, 8'hFF};
        vecs[9]  = '{"ch1_b3",      7'h19, 8'h00, 8'hFF};
        vecs[10] = '{"above_map",   7'h1A, 8'hFF, 8'hFF};
        vecs[11] = '{"below_map",   7'h0F, 8'hFF, 8'hFF};
        vecs[12] = '{"status_clr",  7'h10, 8'h00, 8'h00};

        // Reset state
        tick(2);
        chk("rst_sr", sr32, 0);
        chk("rst_bus", bus32, 8'hFF);
        chk("rst_dbg", dbg32, 0);
        rst_n = 1'b1;

        // ch0 low 100 cycles, then hardware latch
        pm = 2'b10;
        tick(100);
        chk("dbg_cnt", dbg32, 2'b01);
        chk("sr_before", sr32, 0);
        pm = 2'b11; latch = 1'b1;
        tick();
        latch = 1'b0;
        chk("sr_set", sr32, 1);
        wr_reg(7'h12, 8'h55);   // RO, ignored
        wr_reg(7'h10, 8'hFF);   // RO, ignored
        wr_reg(7'h1A, 8'hFF);   // unmapped, ignored
        for (int i = 0; i < 13; i++) begin
            rd_reg(vecs[i].addr, d32, d8);
            chk({vecs[i].name, "_32"}, d32, vecs[i].exp32);
            chk({vecs[i].name, "_8"},  d8,  vecs[i].exp8);
        end
        tick();
        chk("bus_release", bus32, 8'hFF);
        chk("sr_cleared", sr32, 0);

        // 300 cycles: 8-bit counter saturates, 32-bit holds 300
        pm = 2'b10;
        tick(300);
        pm = 2'b11;
        pulse_latch();
        rd_reg(7'h12, d32, d8);
        chk("sat_b0_32", d32, 8'h2C);
        chk("sat_b0_8", d8, 8'hFF);
        rd_reg(7'h13, d32, d8);
        chk("sat_b1_32", d32, 8'h01);
        chk("sat_ch1_8", d8, 8'h00);
        rd_reg(7'h10, d32, d8);
        chk("sat_status_32", d32, 8'h80);
        chk("sat_status_8", d8, 8'h81);
        pulse_latch();
        rd_reg(7'h12, d32, d8);
        chk("unsat_b0_8", d8, 8'h00);
        chk("unsat_b0_32", d32, 8'h00);
        rd_reg(7'h10, d32, d8);
        chk("unsat_status_8", d8, 8'h80);

        // Enable control: 50 disabled cycles, 20 enabled, soft latch
        wr_reg(7'h11, 8'h00);
        pm = 2'b00;
        tick(50);
        wr_reg(7'h11, 8'h01);
        tick(20);
        wr_reg(7'h11, 8'h03);
        pm = 2'b11;
        rd_reg(7'h12, d32, d8);
        chk("en_ch0_32", d32, 8'd20);
        chk("en_ch0_8", d8, 8'd20);
        rd_reg(7'h13, d32, d8);
        chk("en_ch1_8", d8, 8'd20);
        rd_reg(7'h16, d32, d8);
        chk("en_ch1_32", d32, 8'd20);
        rd_reg(7'h11, d32, d8);
        chk("ctrl_read", d32, 8'h01);
        rd_reg(7'h10, d32, d8);
        chk("en_status", d32, 8'h80);

        // Soft latch and hardware edge in one cycle: a single snapshot
        wr = 1'b1; addr = 7'h11; wdata = 8'h03; latch = 1'b1; pm = 2'b10;
        tick();
        wr = 1'b0; latch = 1'b0;
        tick(10);
        pm = 2'b11;
        rd_reg(7'h12, d32, d8);
        chk("dual_snap_ch0", d32, 8'h01);
        rd_reg(7'h16, d32, d8);
        chk("dual_snap_ch1", d32, 8'h01);
        rd_reg(7'h10, d32, d8);
        chk("dual_status", d32, 8'h80);
        wr_reg(7'h11, 8'h03);
        rd_reg(7'h12, d32, d8);
        chk("after_dual_ch0_32", d32, 8'd11);
        chk("after_dual_ch0_8", d8, 8'd11);
        rd_reg(7'h16, d32, d8);
        chk("after_dual_ch1", d32, 8'h00);

        // STATUS read in the same cycle as a latch event
        rd_reg(7'h10, d32, d8);
        chk("pre_status", d32, 8'h80);
        rd = 1'b1; addr = 7'h10; latch = 1'b1;
        tick();
        rd = 1'b0; latch = 1'b0;
        chk("coinc_status", bus32, 8'h00);
        chk("coinc_sr", sr32, 1);
        tick();
        rd_reg(7'h10, d32, d8);
        chk("coinc_status2", d32, 8'h80);
        chk("coinc_sr_clr", sr32, 0);

        // Reset mid-count with latch held high across release
        pm = 2'b10;
        tick(10);
        latch = 1'b1;
        tick();
        tick(5);
        wr_reg(7'h11, 8'h00);
        tick(3);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_sr", sr32, 0);
        chk("mid_rst_bus", bus32, 8'hFF);
        chk("mid_rst_dbg", dbg32, 0);
        tick();
        rst_n = 1'b1; pm = 2'b11;
        tick(3);
        chk("no_false_latch", sr32, 0);
        rd_reg(7'h11, d32, d8);
        chk("rst_ctrl", d32, 8'h01);
        rd_reg(7'h10, d32, d8);
        chk("rst_status", d32, 8'h00);
        rd_reg(7'h12, d32, d8);
        chk("rst_latched", d32, 8'h00);
        latch = 1'b0; tick();
        latch = 1'b1; tick();
        latch = 1'b0;
        chk("rearm_sr", sr32, 1);
        rd_reg(7'h12, d32, d8);
        chk("rst_cnt_32", d32, 8'h00);
        chk("rst_cnt_8", d8, 8'h00);
        rd_reg(7'h10, d32, d8);
        chk("rearm_status", d32, 8'h80);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
